bcd_serial_addsub: RTL and testbench

Digit-serial, multi-digit BCD adder/subtractor controller that feeds one BCD digit per cycle into the team's 4-bit ripple adder (fulladd4).
- Applies decimal correction (+6) to each digit.
- Forms the 10's complement for subtraction and re-complements negative results.
- Sits between the operand source (valid/ready upstream) and the display/result consumer (valid/ready downstream).

---
 rtl/bcd_pkg.sv | 16 +
 rtl/bcd_digit_stage.sv | 33 +++
 rtl/fulladd4.sv | 24 ++
 rtl/bcd_serial_addsub.sv | 202 ++++++++++++++++++++
 tb/tb_bcd_serial_addsub.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD adder/subtractor.
package bcd_pkg;

  localparam int unsigned DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_FIX = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_COMP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/bcd_digit_stage.sv
// One BCD digit: optional 9's complement of y, binary add, then +6 decimal correction.
module bcd_digit_stage
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] x_i,
  input  logic [DIGIT_W-1:0] y_i,
  input  logic               cin_i,
  input  logic               comp_en_i,
  output logic [DIGIT_W-1:0] digit_o,
  output logic               cout_o
);

  logic [DIGIT_W-1:0] y_eff;
  logic [DIGIT_W-1:0] bin_sum;
  logic               bin_cout;
  logic               over9;

  // Wraps mod 16 for non-BCD y, matching the behaviour without input checking.
  assign y_eff = comp_en_i ? DIGIT_W'(BCD_MAX - y_i) : y_i;

  fulladd4 u_add (
    .a_i    (x_i),
    .b_i    (y_eff),
    .cin_i  (cin_i),
    .sum_o  (bin_sum),
    .cout_o (bin_cout)
  );

  assign over9   = bin_cout | (bin_sum > BCD_MAX);
  assign digit_o = over9 ? DIGIT_W'(bin_sum + BCD_FIX) : bin_sum;
  assign cout_o  = over9;

endmodule

// File: rtl/fulladd4.sv
// 4-bit ripple-carry binary adder.
module fulladd4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);

  logic [4:0] carry;

  always_comb begin
    carry    = '0;
    sum_o    = '0;
    carry[0] = cin_i;
    for (int i = 0; i < 4; i++) begin
      sum_o[i]   = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign cout_o = carry[4];

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial NDIG-digit BCD add/subtract controller with valid/ready handshakes.
// Optional BCD_INPUT_CHECK_EN: reject operands containing non-BCD digits via err.
module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter int unsigned NDIG = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DIGIT_W*NDIG-1:0] a,
  input  logic [DIGIT_W*NDIG-1:0] b,
  input  logic                    sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DIGIT_W*NDIG-1:0] result,
  output logic                    sign,
  output logic                    cout,
  output logic                    err
);

  localparam int unsigned W     = DIGIT_W * NDIG;
  localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_e             state_q, state_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic               sub_q, sub_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       result_q, result_d;
  logic               sign_q, sign_d;
  logic               cout_q, cout_d;
  logic               out_valid_q, out_valid_d;
  logic               bad_digit;

  logic [DIGIT_W-1:0] st_x, st_y, st_digit;
  logic               st_comp, st_cout;
  logic               last_digit;

  assign last_digit = (idx_q == IDX_W'(NDIG - 1));

  // ADD feeds a/b digits; COMP re-complements the stored result (x = 0).
  always_comb begin
    st_x    = a_q[idx_q*DIGIT_W +: DIGIT_W];
    st_y    = b_q[idx_q*DIGIT_W +: DIGIT_W];
    st_comp = sub_q;
    if (state_q == ST_COMP) begin
      st_x    = '0;
      st_y    = result_q[idx_q*DIGIT_W +: DIGIT_W];
      st_comp = 1'b1;
    end
  end

  bcd_digit_stage u_stage (
    .x_i       (st_x),
    .y_i       (st_y),
    .cin_i     (carry_q),
    .comp_en_i (st_comp),
    .digit_o   (st_digit),
    .cout_o    (st_cout)
  );

`ifdef BCD_INPUT_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < int'(NDIG); i++) begin
      if ((a[i*DIGIT_W +: DIGIT_W] > BCD_MAX) || (b[i*DIGIT_W +: DIGIT_W] > BCD_MAX)) begin
        bad_digit = 1'b1;
      end
    end
  end
`else
  assign bad_digit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sub_d       = sub_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    result_d    = result_q;
    sign_d      = sign_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;
`ifdef BCD_INPUT_CHECK_EN
    err_d       = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          sub_d    = sub;
          carry_d  = sub;
          idx_d    = '0;
          result_d = '0;
          sign_d   = 1'b0;
          cout_d   = 1'b0;
          state_d  = ST_ADD;
`ifdef BCD_INPUT_CHECK_EN
          err_d    = bad_digit;
          if (bad_digit) begin
            state_d     = ST_DONE;
            out_valid_d = 1'b1;
          end
`endif
        end
      end
      ST_ADD: begin
        result_d[idx_q*DIGIT_W +: DIGIT_W] = st_digit;
        carry_d = st_cout;
        idx_d   = idx_q + IDX_W'(1);
        if (last_digit) begin
          if (!sub_q) begin
            cout_d      = st_cout;
            state_d     = ST_DONE;
            out_valid_d = 1'b1;
          end else if (st_cout) begin
            sign_d      = 1'b0;
            state_d     = ST_DONE;
            out_valid_d = 1'b1;
          end else begin
            // No borrow-free carry out: result is the 10's complement of |a-b|.
            sign_d  = 1'b1;
            carry_d = 1'b1;
            idx_d   = '0;
            state_d = ST_COMP;
          end
        end
      end
      ST_COMP: begin
        result_d[idx_q*DIGIT_W +: DIGIT_W] = st_digit;
        carry_d = st_cout;
        idx_d   = idx_q + IDX_W'(1);
        if (last_digit) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      sign_q      <= 1'b0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sub_q       <= sub_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      sign_q      <= sign_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef BCD_INPUT_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign in_ready  = rst_n & (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign sign      = sign_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Randomized self-checking bench for bcd_serial_addsub against a decimal-arithmetic model.
module tb_bcd_serial_addsub;

  localparam int unsigned NDIG = 2;
  localparam int unsigned W    = 4 * NDIG;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         sign;
  logic         cout;
  logic         err;

  int n_checks = 0;
  int n_pass   = 0;

  bcd_serial_addsub #(.NDIG(NDIG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .sign      (sign),
    .cout      (cout),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pow10(input int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = int'(NDIG) - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < int'(NDIG); i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic has_bad(input logic [W-1:0] x, input logic [W-1:0] y);
    logic bad = 1'b0;
    for (int i = 0; i < int'(NDIG); i++)
      if (x[i*4 +: 4] > 4'd9 || y[i*4 +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r;
    for (int i = 0; i < int'(NDIG); i++) r[i*4 +: 4] = 4'($urandom_range(9));
    return r;
  endfunction

  // Drive one operation, check latency and outputs, then hold off the consumer for `hold` cycles.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv, input int hold);
    int           va, vb, d, k, guard;
    logic [W-1:0] exp_res;
    logic         exp_sign, exp_cout, exp_err;
    int           exp_lat;
    logic [W-1:0] held;

    va = bcd2int(av);
    vb = bcd2int(bv);
    exp_err = 1'b0;
    if (!sv) begin
      d        = va + vb;
      exp_res  = int2bcd(d % pow10(NDIG));
      exp_cout = (d >= pow10(NDIG));
      exp_sign = 1'b0;
      exp_lat  = NDIG + 1;
    end else begin
      d        = va - vb;
      exp_cout = 1'b0;
      exp_sign = (d < 0);
      exp_res  = int2bcd(d < 0 ? -d : d);
      exp_lat  = (d < 0) ? 2 * NDIG + 1 : NDIG + 1;
    end
`ifdef BCD_INPUT_CHECK_EN
    if (has_bad(av, bv)) begin
      exp_err  = 1'b1;
      exp_res  = '0;
      exp_sign = 1'b0;
      exp_cout = 1'b0;
      exp_lat  = 1;
    end
`endif

    @(negedge clk);
    in_valid = 1'b1;
    a = av;
    b = bv;
    sub = sv;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("accept_timeout", 32'(guard), 32'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = rand_bcd();
    b = rand_bcd();
    k = 1;
    while (!out_valid && k < 50) begin
      if (sv && d < 0 && !exp_err && k == int'(NDIG) + 1)
        check("comp_intermediate", 32'(result), 32'(int2bcd(pow10(NDIG) + d)));
      @(negedge clk);
      k++;
    end
    check("latency", 32'(k), 32'(exp_lat));
    check("result", 32'(result), 32'(exp_res));
    check("sign", 32'(sign), 32'(exp_sign));
    check("cout", 32'(cout), 32'(exp_cout));
    check("err", 32'(err), 32'(exp_err));
    held = result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_result", 32'(result), 32'(held));
      check("hold_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_pulse_end", 32'(out_valid), 32'd0);
    check("ready_after", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", {29'd0, sign, cout, err}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);

    run_op(8'h47, 8'h38, 1'b0, 0);
    run_op(8'h99, 8'h01, 1'b0, 0);
    run_op(8'h52, 8'h27, 1'b1, 0);
    run_op(8'h33, 8'h33, 1'b1, 0);
    run_op(8'h27, 8'h52, 1'b1, 4);
    run_op(8'h00, 8'h99, 1'b1, 1);
    run_op(8'h99, 8'h99, 1'b0, 2);

    // Reset in the middle of an addition, after the first digit has been written.
    @(negedge clk);
    in_valid = 1'b1;
    a = 8'h47;
    b = 8'h38;
    sub = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_flags", {29'd0, sign, cout, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h47, 8'h38, 1'b0, 0);

`ifdef BCD_INPUT_CHECK_EN
    run_op(8'h4A, 8'h12, 1'b0, 0);
`endif

    for (int n = 0; n < 40; n++) begin
      run_op(rand_bcd(), rand_bcd(), 1'($urandom_range(1)), int'($urandom_range(3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
